// File: rtl/lut_loader.sv
// lut_loader: writer side of the 3BC branch/address lookup table.
// A loader streams two-byte frames (header carrying index and the upper
// data bits, then the low data byte); each completed frame is written into
// a 16-entry register table. The table is read combinationally via i_Index.
module lut_loader #(
  parameter int ENTRIES = 16,
  parameter int WIDTH   = 10
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [7:0]         i_InData,
  input  logic               i_InValid,
  output logic               o_InReady,
  input  logic               i_Lock,
  input  logic [3:0]         i_Index,
  output logic [WIDTH-1:0]   o_Out,
  output logic [ENTRIES-1:0] o_Loaded,
  output logic               o_Done,
  output logic               o_Error
);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    LO    = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_index;
  logic [1:0]         r_hi;
  logic [7:0]         r_lo;
  logic [WIDTH-1:0]   r_table [ENTRIES];
  logic [ENTRIES-1:0] r_loaded;
  logic               r_done;
  logic               r_error;

  logic               w_xfer;
  logic               w_hdrBad;

  // Handshake: no bytes during reset, while locked, or in the write cycle.
  assign o_InReady = i_Reset && !i_Lock && (r_state != WRITE);
  assign w_xfer    = i_InValid && o_InReady;
  assign w_hdrBad  = (i_InData[3:2] != 2'b00);

  // Frame assembly and table update; a reset mid-frame discards the partial entry.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state  <= HDR;
      r_index  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_loaded <= '0;
      r_error  <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      case (r_state)
        HDR: begin
          if (w_xfer) begin
            if (w_hdrBad) begin
              r_error <= 1'b1;
            end else begin
              r_index <= i_InData[7:4];
              r_hi    <= i_InData[1:0];
              r_state <= LO;
            end
          end
        end
        LO: begin
          if (w_xfer) begin
            r_lo    <= i_InData;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_table[r_index]  <= {r_hi, r_lo};
          r_loaded[r_index] <= 1'b1;
          r_state           <= HDR;
        end
        default: begin
          r_state <= HDR;
        end
      endcase
    end
  end

  // Done trails the Loaded vector by one cycle and only clears on reset.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= &r_loaded;
    end
  end

  assign o_Out    = r_table[i_Index];
  assign o_Loaded = r_loaded;
  assign o_Done   = r_done;
  assign o_Error  = r_error;

endmodule

// File: tb/tb_lut_loader.sv
// tb_lut_loader: scoreboard bench for lut_loader. A transaction-level model
// of the table predicts every completed write; a monitor pops predictions
// when each write becomes visible and compares the read port against them.
module tb_lut_loader;

  logic        i_Clk;
  logic        i_Reset;
  logic [7:0]  i_InData;
  logic        i_InValid;
  logic        o_InReady;
  logic        i_Lock;
  logic [3:0]  i_Index;
  logic [9:0]  o_Out;
  logic [15:0] o_Loaded;
  logic        o_Done;
  logic        o_Error;

  // Read index is shared between monitor and stimulus through a mux.
  logic [3:0]  stimIndex;
  logic [3:0]  monIndex;
  logic        monActive;
  assign i_Index = monActive ? monIndex : stimIndex;

  lut_loader #(.ENTRIES(16), .WIDTH(10)) dut (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_InData  (i_InData),
    .i_InValid (i_InValid),
    .o_InReady (o_InReady),
    .i_Lock    (i_Lock),
    .i_Index   (i_Index),
    .o_Out     (o_Out),
    .o_Loaded  (o_Loaded),
    .o_Done    (o_Done),
    .o_Error   (o_Error)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Free-running cycle counter used to schedule when a write must be visible.
  int cycle = 0;
  always @(posedge i_Clk) cycle <= cycle + 1;

  int vectors = 0;
  int miscompares = 0;

  // Counts cycles where the block refuses bytes, inside a chosen window.
  int  notReadyCnt = 0;
  bit  countEn = 0;
  always @(negedge i_Clk) begin
    if (countEn && !o_InReady) notReadyCnt++;
  end

  // Expected write record: which entry, its value, error flag at that time,
  // and the first cycle in which the new value must be readable.
  typedef struct {
    int         idx;
    logic [9:0] value;
    logic       err;
    int         due;
  } exp_t;
  exp_t q[$];

  // Transaction-level model of the table.
  logic [9:0]  mTable [16];
  logic [15:0] mLoaded;
  logic        mError;
  bit          mExpectHdr;
  int          mIdx;
  logic [1:0]  mHi;

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mTable[i] = 10'd0;
    mLoaded    = 16'd0;
    mError     = 1'b0;
    mExpectHdr = 1'b1;
    mIdx       = 0;
    mHi        = 2'd0;
  endtask

  // Apply one accepted byte to the model; a completed frame yields a prediction.
  task automatic modelByte(input logic [7:0] b, input int due);
    exp_t e;
    if (mExpectHdr) begin
      if (b[3:2] != 2'b00) begin
        mError = 1'b1;
      end else begin
        mIdx       = int'(b[7:4]);
        mHi        = b[1:0];
        mExpectHdr = 1'b0;
      end
    end else begin
      mTable[mIdx]  = {mHi, b};
      mLoaded[mIdx] = 1'b1;
      mExpectHdr    = 1'b1;
      e.idx   = mIdx;
      e.value = {mHi, b};
      e.err   = mError;
      e.due   = due;
      q.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: bound expired, got no progress, expected completion", name);
  endtask

  // Offer one byte and wait until it is accepted; InValid drops afterwards.
  task automatic applyStimulus(input logic [7:0] b);
    int  waited;
    bit  accepted;
    waited   = 0;
    accepted = 0;
    i_InData  = b;
    i_InValid = 1'b1;
    while (!accepted) begin
      @(negedge i_Clk);
      if (o_InReady) begin
        @(posedge i_Clk);
        #1;
        modelByte(b, cycle + 1);
        accepted = 1;
      end else begin
        waited++;
        if (waited > 50) begin
          timeoutFail("byte_transfer");
          accepted = 1;
        end else begin
          @(posedge i_Clk);
          #1;
        end
      end
    end
    i_InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  // Wait for every predicted write to be checked by the monitor.
  task automatic waitDrain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(posedge i_Clk);
      n++;
    end
    if (q.size() > 0) begin
      timeoutFail("scoreboard_drain");
      q.delete();
    end
    idle(2);
  endtask

  task automatic sendFrame(input int idx, input logic [9:0] value);
    applyStimulus({4'(idx), 2'b00, value[9:8]});
    applyStimulus(value[7:0]);
  endtask

  // Monitor: once a predicted write is due, read that entry and compare.
  initial begin
    exp_t e;
    monActive = 1'b0;
    monIndex  = 4'd0;
    forever begin
      @(negedge i_Clk);
      if (q.size() > 0 && cycle >= q[0].due) begin
        e = q.pop_front();
        monIndex  = 4'(e.idx);
        monActive = 1'b1;
        #1;
        checkOutput($sformatf("out_idx%0d", e.idx), 32'(o_Out), 32'(e.value));
        checkOutput($sformatf("loaded_idx%0d", e.idx), 32'(o_Loaded[e.idx]), 32'd1);
        checkOutput("error_at_write", 32'(o_Error), 32'(e.err));
        monActive = 1'b0;
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          k;
    int          idx;
    logic [9:0]  v;
    logic [7:0]  hdr;

    i_Reset   = 1'b0;
    i_InData  = 8'h00;
    i_InValid = 1'b0;
    i_Lock    = 1'b0;
    stimIndex = 4'd0;
    modelReset();

    // Reset state.
    idle(2);
    checkOutput("reset_inready", 32'(o_InReady), 32'd0);
    checkOutput("reset_loaded", 32'(o_Loaded), 32'(mLoaded));
    checkOutput("reset_done", 32'(o_Done), 32'd0);
    checkOutput("reset_error", 32'(o_Error), 32'(mError));
    checkOutput("reset_out", 32'(o_Out), 32'd0);
    i_Reset = 1'b1;
    idle(1);

    // Single frame: index 5, data 0x268; no bypass during the write cycle.
    applyStimulus(8'h52);
    applyStimulus(8'h68);
    stimIndex = 4'd5;
    @(negedge i_Clk);
    #1;
    checkOutput("write_cycle_inready", 32'(o_InReady), 32'd0);
    checkOutput("no_bypass_out", 32'(o_Out), 32'd0);
    waitDrain();
    checkOutput("first_loaded", 32'(o_Loaded), 32'(mLoaded));
    checkOutput("first_done", 32'(o_Done), 32'(&mLoaded));

    // Bad header is dropped and sets the sticky error; next frame still lands.
    applyStimulus(8'h36);
    idle(1);
    checkOutput("error_set", 32'(o_Error), 32'(mError));
    applyStimulus(8'h30);
    applyStimulus(8'hFF);
    waitDrain();

    // Lock after a header holds the half frame; resumes when Lock falls.
    applyStimulus(8'h71);
    i_Lock    = 1'b1;
    i_InData  = 8'h22;
    i_InValid = 1'b1;
    repeat (5) begin
      @(negedge i_Clk);
      checkOutput("ready_under_lock", 32'(o_InReady), 32'd0);
      @(posedge i_Clk);
      #1;
    end
    stimIndex = 4'd7;
    #1;
    checkOutput("locked_no_change", 32'(o_Out), 32'(mTable[7]));
    i_Lock = 1'b0;
    applyStimulus(8'h22);
    waitDrain();

    // Rewrite an entry; Lock rising in the write cycle must not cancel it.
    sendFrame(2, 10'h3FF);
    waitDrain();
    sendFrame(2, 10'h001);
    i_Lock = 1'b1;
    idle(2);
    i_Lock = 1'b0;
    waitDrain();
    checkOutput("rewrite_loaded2", 32'(o_Loaded[2]), 32'd1);

    // Fill every entry back-to-back; one stall per entry, Done a cycle late.
    notReadyCnt = 0;
    countEn     = 1;
    for (int i = 0; i < 16; i++) begin
      sendFrame(i, 10'(i * 3));
    end
    @(negedge i_Clk);
    @(negedge i_Clk);
    checkOutput("done_not_early", 32'(o_Done), 32'd0);
    @(negedge i_Clk);
    checkOutput("done_rise", 32'(o_Done), 32'd1);
    countEn = 0;
    checkOutput("stall_cycles", 32'(notReadyCnt), 32'd16);
    waitDrain();

    // Randomised frames with bad headers, idle gaps and Lock pulses.
    for (int n = 0; n < 60; n++) begin
      idx = int'($urandom_range(0, 15));
      v   = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) begin
        hdr = {4'(idx), 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))};
        applyStimulus(hdr);
      end
      idle(int'($urandom_range(0, 2)));
      hdr = {4'(idx), 2'b00, v[9:8]};
      if ($urandom_range(0, 4) == 0) begin
        i_Lock    = 1'b1;
        i_InData  = hdr;
        i_InValid = 1'b1;
        idle(int'($urandom_range(1, 4)));
        i_Lock = 1'b0;
      end
      applyStimulus(hdr);
      if ($urandom_range(0, 4) == 0) begin
        i_Lock    = 1'b1;
        i_InData  = v[7:0];
        i_InValid = 1'b1;
        idle(int'($urandom_range(1, 4)));
        i_Lock = 1'b0;
      end
      applyStimulus(v[7:0]);
    end
    waitDrain();
    checkOutput("random_done", 32'(o_Done), 32'(&mLoaded));
    checkOutput("random_error", 32'(o_Error), 32'(mError));
    checkOutput("random_loaded", 32'(o_Loaded), 32'(mLoaded));

    // Reset between header and low byte clears everything at once.
    applyStimulus(8'h91);
    i_Reset = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_inready", 32'(o_InReady), 32'd0);
    checkOutput("midreset_loaded", 32'(o_Loaded), 32'(mLoaded));
    checkOutput("midreset_done", 32'(o_Done), 32'd0);
    checkOutput("midreset_error", 32'(o_Error), 32'(mError));
    for (int i = 0; i < 16; i++) begin
      stimIndex = 4'(i);
      #1;
      checkOutput($sformatf("midreset_out%0d", i), 32'(o_Out), 32'(mTable[i]));
    end
    idle(2);
    i_Reset = 1'b1;
    applyStimulus(8'h45);
    applyStimulus(8'h67);
    waitDrain();

    // Final sweep of the whole table and status against the model.
    idle(3);
    for (int i = 0; i < 16; i++) begin
      stimIndex = 4'(i);
      #1;
      checkOutput($sformatf("final_out%0d", i), 32'(o_Out), 32'(mTable[i]));
    end
    checkOutput("final_loaded", 32'(o_Loaded), 32'(mLoaded));
    checkOutput("final_done", 32'(o_Done), 32'(&mLoaded));
    checkOutput("final_error", 32'(o_Error), 32'(mError));
    checkOutput("final_inready", 32'(o_InReady), 32'd1);
    k = q.size();
    checkOutput("final_queue_empty", 32'(k), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
